fb_writer: RTL and testbench
============================

FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 The port CLK_100M (input, 1 bit) SHALL be the single 100 MHz clock; all state SHALL update on its rising edge.
REQ-002 The port SYS_RST (input, 1 bit) SHALL be the system reset, which is synchronous and active-high.
REQ-003 The port PIX_DVLD (input, 1 bit) SHALL indicate a valid pixel on PIX_ADDR/PIX_DATA in the current cycle.
REQ-004 The port PIX_ADDR (input, 18 bits) SHALL carry the frame-buffer base address of the current region; it is constant across a region.
REQ-005 The port PIX_DATA (input, 16 bits) SHALL carry the pixel word.
REQ-006 The port MEM_WE (output, 1 bit) SHALL be the memory write request.
REQ-007 The port MEM_ADDR (output, 18 bits) SHALL be the memory write address.
REQ-008 The port MEM_WDATA (output, 16 bits) SHALL be the memory write data.
REQ-009 The port MEM_ACK (input, 1 bit) SHALL be the memory acknowledge; the write completes in a cycle where MEM_WE=1 and MEM_ACK=1.
REQ-010 The port FB_BUSY (output, 1 bit) SHALL equal (FIFO not empty) OR MEM_WE.
REQ-011 The port OVF_ERR (output, 1 bit) SHALL be a sticky pixel-dropped flag.
REQ-012 The parameter P_FIFO_DEPTH (default 16, power of 2) SHALL set the number of buffered {address, data} entries.

Function
REQ-013 Address generation: on each cycle with PIX_DVLD=1, the write address SHALL equal PIX_ADDR + offset, computed modulo 2^18.
REQ-014 The offset SHALL reset to 0 when PIX_DVLD was 0 in the previous cycle, or when PIX_ADDR differs from the base of the previous valid pixel; otherwise it SHALL increment by 1 per valid pixel.
REQ-015 The offset SHALL increment even when the pixel is dropped, so that later pixels land at their correct addresses.
REQ-016 Push: each valid pixel SHALL be written into a first-word-fall-through FIFO as {address, data}.
REQ-017 When the FIFO is full and no pop occurs in the same cycle, the pixel SHALL be dropped and OVF_ERR SHALL set to 1; OVF_ERR clears only on reset.
REQ-018 When the FIFO is full and a pop occurs in the same cycle, the push SHALL be accepted.
REQ-019 The write FSM SHALL have two states, IDLE and WRITE.
REQ-020 IDLE: when the FIFO is not empty, the FSM SHALL register the FIFO head into MEM_ADDR/MEM_WDATA, set MEM_WE=1, and go to WRITE.
REQ-021 WRITE: while MEM_ACK=0, MEM_WE, MEM_ADDR and MEM_WDATA SHALL hold stable.
REQ-022 WRITE: on MEM_ACK=1, the FSM SHALL pop the head. If another entry remains, it SHALL present that entry on the next cycle with MEM_WE held at 1 (back-to-back operation).
REQ-023 WRITE: on MEM_ACK=1 with no remaining entry, MEM_WE SHALL go to 0 and the FSM SHALL return to IDLE.
REQ-024 Latency: a pixel sampled at edge N into an empty, idle block SHALL appear with MEM_WE=1 after edge N+2.
REQ-025 With MEM_ACK held at 1, sustained throughput SHALL be one write per cycle.
REQ-026 MEM_ACK while MEM_WE=0 SHALL be ignored.
REQ-027 Write order SHALL equal pixel arrival order; no entry SHALL be written twice.

Reset
REQ-028 While SYS_RST=1, at the clock edge the block SHALL empty the FIFO, enter IDLE, and clear the offset and the previous-DVLD/base registers.
REQ-029 While SYS_RST=1, MEM_WE=0, MEM_ADDR=18'h0, MEM_WDATA=16'h0, FB_BUSY=0 and OVF_ERR=0.
REQ-030 A reset during a pending write SHALL abandon that write immediately; pixels presented during reset SHALL be ignored.

Configuration
REQ-031 When the macro FB_WRITER_DROP_CNT_EN is defined, the block SHALL add an output DROP_CNT (16 bits, reset 0) that increments on each dropped pixel and saturates at 16'hFFFF.
REQ-032 When FB_WRITER_DROP_CNT_EN is undefined, the DROP_CNT port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Three pixels (PIX_ADDR=0, data 000F/00F0/0F00) with MEM_ACK tied to 1 -> MEM_WE high for 3 consecutive cycles starting 2 cycles after the first pixel, with MEM_ADDR 0,1,2.
REQ-034 400 pixels at base 0, then 400 contiguous pixels at base 18'h20000, with MEM_ACK=1 -> the 401st write goes to 18'h20000 and the last write to 18'h2018F.
REQ-035 MEM_ACK=0 for 10 cycles during WRITE -> MEM_WE/MEM_ADDR/MEM_WDATA stable throughout; writes resume in order after MEM_ACK=1.
REQ-036 MEM_ACK=0 with 20 contiguous pixels at depth 16 -> OVF_ERR=1 and DROP_CNT=4 (macro defined); after acknowledging, exactly 16 writes at addresses 0..15.
REQ-037 SYS_RST pulsed while 5 entries are queued -> next cycle MEM_WE=0, FB_BUSY=0, no further writes, OVF_ERR=0.
REQ-038 PIX_DVLD low for 1 cycle between two bursts at the same base 18'h100 -> the second burst restarts at address 18'h100.

Source files
------------

// File: rtl/fb_writer_if.sv
// Pixel-input and memory-write signal bundle for fb_writer.
// DROP_CNT is present only when FB_WRITER_DROP_CNT_EN is defined.
interface fb_writer_if;
    logic        PIX_DVLD;
    logic [17:0] PIX_ADDR;
    logic [15:0] PIX_DATA;
    logic        MEM_WE;
    logic [17:0] MEM_ADDR;
    logic [15:0] MEM_WDATA;
    logic        MEM_ACK;
    logic        FB_BUSY;
    logic        OVF_ERR;
`ifdef FB_WRITER_DROP_CNT_EN
    logic [15:0] DROP_CNT;

    // master: the frame-buffer writer itself (it issues the memory writes)
    modport master (
        input  PIX_DVLD, PIX_ADDR, PIX_DATA, MEM_ACK,
        output MEM_WE, MEM_ADDR, MEM_WDATA, FB_BUSY, OVF_ERR, DROP_CNT
    );
    modport slave (
        output PIX_DVLD, PIX_ADDR, PIX_DATA, MEM_ACK,
        input  MEM_WE, MEM_ADDR, MEM_WDATA, FB_BUSY, OVF_ERR, DROP_CNT
    );
`else
    modport master (
        input  PIX_DVLD, PIX_ADDR, PIX_DATA, MEM_ACK,
        output MEM_WE, MEM_ADDR, MEM_WDATA, FB_BUSY, OVF_ERR
    );
    modport slave (
        output PIX_DVLD, PIX_ADDR, PIX_DATA, MEM_ACK,
        input  MEM_WE, MEM_ADDR, MEM_WDATA, FB_BUSY, OVF_ERR
    );
`endif
endinterface

// File: rtl/fb_writer.sv
// Frame-buffer writer: region address generation, FWFT FIFO and a two-state memory write FSM.
// Optional saturating drop counter on DROP_CNT when FB_WRITER_DROP_CNT_EN is defined.
module fb_writer #(
    parameter int P_FIFO_DEPTH = 16
) (
    input logic       CLK_100M,
    input logic       SYS_RST,
    fb_writer_if.master bus
);
    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam int PTR_W  = $clog2(P_FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    logic                     dvld_prev;
    logic [ADDR_W-1:0]        base_prev;
    logic [ADDR_W-1:0]        offset_r;
    logic [ADDR_W-1:0]        offset_nxt;
    logic                     vld_p0;
    logic [ADDR_W-1:0]        addr_p0;
    logic [DATA_W-1:0]        data_p0;

    logic [ADDR_W-1:0]        fifo_addr [P_FIFO_DEPTH];
    logic [DATA_W-1:0]        fifo_data [P_FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         rd_ptr_next;
    logic [CNT_W-1:0]         count;
    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     pop;
    logic                     drop;
    logic                     ovf_err;

    state_t                   state;
    state_t                   state_nxt;
    logic                     mem_we;
    logic                     mem_we_nxt;
    logic [ADDR_W-1:0]        mem_addr;
    logic [ADDR_W-1:0]        mem_addr_nxt;
    logic [DATA_W-1:0]        mem_wdata;
    logic [DATA_W-1:0]        mem_wdata_nxt;

    // ---- stage p0: region offset and address generation ----
    // Offset keeps counting on dropped pixels because the drop decision is made later at the FIFO.
    always_comb begin
        offset_nxt = offset_r + ADDR_W'(1);
        if (!dvld_prev || (bus.PIX_ADDR != base_prev)) begin
            offset_nxt = '0;
        end
    end

    always_ff @(posedge CLK_100M) begin
        if (SYS_RST) begin
            dvld_prev <= 1'b0;
            base_prev <= '0;
            offset_r  <= '0;
            vld_p0    <= 1'b0;
        end else begin
            dvld_prev <= bus.PIX_DVLD;
            vld_p0    <= bus.PIX_DVLD;
            if (bus.PIX_DVLD) begin
                base_prev <= bus.PIX_ADDR;
                offset_r  <= offset_nxt;
            end
        end
    end

    always_ff @(posedge CLK_100M) begin
        if (bus.PIX_DVLD) begin
            addr_p0 <= bus.PIX_ADDR + offset_nxt;
            data_p0 <= bus.PIX_DATA;
        end
    end

    // ---- stage p1: FIFO push / drop ----
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    always_comb begin
        full        = (count == CNT_W'(P_FIFO_DEPTH));
        empty       = (count == '0);
        push        = vld_p0 && (!full || pop);
        drop        = vld_p0 && full && !pop;
        rd_ptr_next = rd_ptr + PTR_W'(1);
    end

    always_ff @(posedge CLK_100M) begin
        if (SYS_RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_next;
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            if (drop) begin
                ovf_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_100M) begin
        if (push) begin
            fifo_addr[wr_ptr] <= addr_p0;
            fifo_data[wr_ptr] <= data_p0;
        end
    end

    // ---- stage p2: memory write FSM ----
    // The head stays in the FIFO until acknowledged; on ack the entry behind it is presented directly.
    always_comb begin
        state_nxt     = state;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    mem_addr_nxt  = fifo_addr[rd_ptr];
                    mem_wdata_nxt = fifo_data[rd_ptr];
                    mem_we_nxt    = 1'b1;
                    state_nxt     = WRITE;
                end
            end
            WRITE: begin
                if (bus.MEM_ACK) begin
                    pop = 1'b1;
                    if (count > CNT_W'(1)) begin
                        mem_addr_nxt  = fifo_addr[rd_ptr_next];
                        mem_wdata_nxt = fifo_data[rd_ptr_next];
                    end else begin
                        mem_we_nxt = 1'b0;
                        state_nxt  = IDLE;
                    end
                end
            end
            default: begin
                mem_we_nxt = 1'b0;
                state_nxt  = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_100M) begin
        if (SYS_RST) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
        end
    end

    assign bus.MEM_WE    = mem_we;
    assign bus.MEM_ADDR  = mem_addr;
    assign bus.MEM_WDATA = mem_wdata;
    assign bus.FB_BUSY   = !empty || mem_we;
    assign bus.OVF_ERR   = ovf_err;

`ifdef FB_WRITER_DROP_CNT_EN
    logic [15:0] drop_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    always_ff @(posedge CLK_100M) begin
        if (SYS_RST) begin
            drop_cnt <= '0;
        end else if (drop) begin
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

    assign bus.DROP_CNT = drop_cnt;
`endif

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer: directed scenarios plus randomized traffic against a
// per-pixel address model and an in-order expected-write queue.
module tb_fb_writer;
    logic clk = 1'b0;
    logic rst;

    fb_writer_if bus();

    fb_writer #(.P_FIFO_DEPTH(16)) dut (
        .CLK_100M (clk),
        .SYS_RST  (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_extra  = 0;
    logic [33:0] exp_q[$];
    int          exp_idx  = 0;
    logic [17:0] wr_log[$];
    logic        hold_vld = 1'b0;
    logic [17:0] hold_addr;
    logic [15:0] hold_data;

    bit          m_prev_dvld;
    logic [17:0] m_prev_base;
    logic [17:0] m_off;

    task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Address rule: offset restarts after a gap or on a new base, else counts every valid pixel.
    task automatic drive_pix(input logic [17:0] base, input logic [15:0] data, input bit enq);
        logic [17:0] off;
        if (!m_prev_dvld || base != m_prev_base) off = 18'd0;
        else off = m_off + 18'd1;
        m_off       = off;
        m_prev_base = base;
        m_prev_dvld = 1'b1;
        bus.PIX_DVLD = 1'b1;
        bus.PIX_ADDR = base;
        bus.PIX_DATA = data;
        if (enq) exp_q.push_back({18'(base + off), data});
        tick();
    endtask

    task automatic idle_cycle();
        bus.PIX_DVLD = 1'b0;
        m_prev_dvld  = 1'b0;
        tick();
    endtask

    task automatic model_reset();
        m_prev_dvld = 1'b0;
        m_prev_base = 18'd0;
        m_off       = 18'd0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        bus.MEM_ACK = 1'b1;
        while ((exp_idx < exp_q.size() || bus.MEM_WE) && n < 300) begin
            idle_cycle();
            n++;
        end
        check(tag, 34'(exp_q.size() - exp_idx), 34'd0);
        check({tag, "_busy"}, 34'(bus.FB_BUSY), 34'd0);
    endtask

    // Write monitor: handshakes seen mid-cycle complete on the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            hold_vld = 1'b0;
            exp_idx  = exp_q.size();
        end else begin
            if (hold_vld) begin
                check("hold_we",   34'(bus.MEM_WE),    34'd1);
                check("hold_addr", 34'(bus.MEM_ADDR),  34'(hold_addr));
                check("hold_data", 34'(bus.MEM_WDATA), 34'(hold_data));
            end
            if (bus.MEM_WE && bus.MEM_ACK) begin
                if (exp_idx < exp_q.size()) begin
                    check("wr_addr", 34'(bus.MEM_ADDR),  34'(exp_q[exp_idx][33:16]));
                    check("wr_data", 34'(bus.MEM_WDATA), 34'(exp_q[exp_idx][15:0]));
                    exp_idx++;
                end else begin
                    n_extra++;
                end
                wr_log.push_back(bus.MEM_ADDR);
            end
            hold_vld  = bus.MEM_WE && !bus.MEM_ACK;
            hold_addr = bus.MEM_ADDR;
            hold_data = bus.MEM_WDATA;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench watchdog");
    end

    initial begin
        int          lb;
        logic [17:0] rbase;
        rst = 1'b1;
        bus.PIX_DVLD = 1'b0;
        bus.PIX_ADDR = 18'd0;
        bus.PIX_DATA = 16'd0;
        bus.MEM_ACK  = 1'b0;
        model_reset();

        // reset state, sampled while reset is still asserted
        tick();
        check("rst_we",    34'(bus.MEM_WE),    34'd0);
        check("rst_addr",  34'(bus.MEM_ADDR),  34'd0);
        check("rst_wdata", 34'(bus.MEM_WDATA), 34'd0);
        check("rst_busy",  34'(bus.FB_BUSY),   34'd0);
        check("rst_ovf",   34'(bus.OVF_ERR),   34'd0);
`ifdef FB_WRITER_DROP_CNT_EN
        check("rst_drop",  34'(bus.DROP_CNT),  34'd0);
`endif
        tick();
        rst = 1'b0;
        idle_cycle();

        // three pixels, ack tied high: MEM_WE after edge N+2 for three cycles
        bus.MEM_ACK = 1'b1;
        drive_pix(18'd0, 16'h000F, 1'b1);
        check("lat_n_we", 34'(bus.MEM_WE), 34'd0);
        drive_pix(18'd0, 16'h00F0, 1'b1);
        check("lat_n1_we", 34'(bus.MEM_WE), 34'd0);
        drive_pix(18'd0, 16'h0F00, 1'b1);
        check("lat_n2_we",   34'(bus.MEM_WE),    34'd1);
        check("lat_n2_addr", 34'(bus.MEM_ADDR),  34'd0);
        check("lat_n2_data", 34'(bus.MEM_WDATA), 34'h000F);
        idle_cycle();
        check("lat_n3_we",   34'(bus.MEM_WE),    34'd1);
        check("lat_n3_addr", 34'(bus.MEM_ADDR),  34'd1);
        check("lat_n3_data", 34'(bus.MEM_WDATA), 34'h00F0);
        idle_cycle();
        check("lat_n4_we",   34'(bus.MEM_WE),    34'd1);
        check("lat_n4_addr", 34'(bus.MEM_ADDR),  34'd2);
        check("lat_n4_data", 34'(bus.MEM_WDATA), 34'h0F00);
        idle_cycle();
        check("lat_n5_we", 34'(bus.MEM_WE), 34'd0);
        drain("lat_drain");

        // gap of one cycle at an unchanged base restarts the offset
        lb = wr_log.size();
        for (int i = 0; i < 4; i++) drive_pix(18'h100, 16'($urandom), 1'b1);
        idle_cycle();
        for (int i = 0; i < 4; i++) drive_pix(18'h100, 16'($urandom), 1'b1);
        drain("gap_drain");
        check("gap_count",  34'(wr_log.size() - lb), 34'd8);
        check("gap_last1",  34'(wr_log[lb + 3]), 34'h103);
        check("gap_second", 34'(wr_log[lb + 4]), 34'h100);

        // 400 + 400 contiguous pixels with a base change, full-rate acknowledge
        lb = wr_log.size();
        for (int i = 0; i < 400; i++) drive_pix(18'h00000, 16'(i), 1'b1);
        for (int i = 0; i < 400; i++) drive_pix(18'h20000, 16'(i + 400), 1'b1);
        repeat (4) idle_cycle();
        check("rate_backlog", 34'(exp_q.size() - exp_idx), 34'd0);
        drain("long_drain");
        check("long_count", 34'(wr_log.size() - lb), 34'd800);
        check("long_401",   34'(wr_log[lb + 400]), 34'h20000);
        check("long_last",  34'(wr_log[lb + 799]), 34'h2018F);

        // stall: ack low for well over 10 cycles while writing
        lb = wr_log.size();
        bus.MEM_ACK = 1'b0;
        for (int i = 0; i < 6; i++) drive_pix(18'h500, 16'(16'hA000 + i), 1'b1);
        repeat (14) idle_cycle();
        check("stall_we",    34'(bus.MEM_WE),   34'd1);
        check("stall_addr",  34'(bus.MEM_ADDR), 34'h500);
        check("stall_busy",  34'(bus.FB_BUSY),  34'd1);
        check("stall_nowr",  34'(wr_log.size() - lb), 34'd0);
        drain("stall_drain");
        check("stall_count", 34'(wr_log.size() - lb), 34'd6);
        check("stall_last",  34'(wr_log[lb + 5]), 34'h505);

        // overflow: 20 pixels into a 16-deep FIFO with no acknowledge
        lb = wr_log.size();
        bus.MEM_ACK = 1'b0;
        for (int i = 0; i < 20; i++) drive_pix(18'd0, 16'(16'hB000 + i), (i < 16));
        repeat (3) idle_cycle();
        check("ovf_flag", 34'(bus.OVF_ERR), 34'd1);
`ifdef FB_WRITER_DROP_CNT_EN
        check("ovf_drops", 34'(bus.DROP_CNT), 34'd4);
`endif
        drain("ovf_drain");
        check("ovf_count", 34'(wr_log.size() - lb), 34'd16);
        check("ovf_first", 34'(wr_log[lb]),      34'd0);
        check("ovf_last",  34'(wr_log[lb + 15]), 34'd15);
        check("ovf_sticky", 34'(bus.OVF_ERR), 34'd1);

        // reset while 5 entries are queued; a pixel offered during reset is ignored
        bus.MEM_ACK = 1'b0;
        for (int i = 0; i < 5; i++) drive_pix(18'h40, 16'(16'hC000 + i), 1'b1);
        repeat (2) idle_cycle();
        rst = 1'b1;
        bus.PIX_DVLD = 1'b1;
        bus.PIX_ADDR = 18'h777;
        bus.PIX_DATA = 16'hDEAD;
        tick();
        check("rstq_we",    34'(bus.MEM_WE),    34'd0);
        check("rstq_busy",  34'(bus.FB_BUSY),   34'd0);
        check("rstq_ovf",   34'(bus.OVF_ERR),   34'd0);
        check("rstq_addr",  34'(bus.MEM_ADDR),  34'd0);
        check("rstq_wdata", 34'(bus.MEM_WDATA), 34'd0);
`ifdef FB_WRITER_DROP_CNT_EN
        check("rstq_drop",  34'(bus.DROP_CNT),  34'd0);
`endif
        rst = 1'b0;
        model_reset();
        lb = wr_log.size();
        bus.MEM_ACK = 1'b1;
        repeat (10) idle_cycle();
        check("rstq_nowr", 34'(wr_log.size() - lb), 34'd0);

        // randomized traffic, flow-limited so nothing is dropped
        rbase = 18'd0;
        for (int c = 0; c < 1500; c++) begin
            bus.MEM_ACK = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0:       rbase = 18'h00000;
                    1:       rbase = 18'h01000;
                    2:       rbase = 18'h3FFF8;
                    default: rbase = 18'($urandom);
                endcase
            end
            if ((exp_q.size() - exp_idx) < 12 && $urandom_range(0, 9) < 7)
                drive_pix(rbase, 16'($urandom), 1'b1);
            else
                idle_cycle();
        end
        drain("rand_drain");
        check("rand_ovf", 34'(bus.OVF_ERR), 34'd0);
        check("extra_writes", 34'(n_extra), 34'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
